// File: rtl/axis_lfsr_checker.sv
// AXI-Stream LFSR traffic checker: sinks packets under randomized backpressure,
// checks length, channel and LFSR payload sequence, and keeps packet/error statistics.
module axis_lfsr_checker #(
  parameter int unsigned          ID_WIDTH   = 10,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TAPS      = DATA_WIDTH'(32'h8020_0003)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [15:0]           cntrl_min_length_i,
  input  logic [15:0]           cntrl_max_length_i,
  input  logic [ID_WIDTH-1:0]   cntrl_min_channel_i,
  input  logic [ID_WIDTH-1:0]   cntrl_max_channel_i,
  input  logic [15:0]           cntrl_ready_mask_i,
  input  logic                  cntrl_clear_i,
  output logic                  pkt_done_o,
  output logic                  pkt_err_o,
  output logic [31:0]           stat_pkt_cnt_o,
  output logic [31:0]           stat_err_cnt_o,
  output logic [3:0]            stat_err_flags_o
);

  localparam int unsigned LEN_W    = 16;
  localparam int unsigned THR_W    = 16;
  localparam int unsigned ERR_W    = 4;
  localparam logic [THR_W-1:0] THR_SEED = 16'hACE1;
  localparam logic [LEN_W-1:0] LEN_MAX  = 16'hFFFF;

  // Error bit positions: {zero_seed, data, channel, length}
  localparam int unsigned E_LEN  = 0;
  localparam int unsigned E_CH   = 1;
  localparam int unsigned E_DATA = 2;
  localparam int unsigned E_ZERO = 3;

  typedef enum logic {S_FIRST, S_BODY} state_t;

  state_t                state;
  logic [THR_W-1:0]      thr_lfsr;
  logic [DATA_WIDTH-1:0] prev_word;
  logic [ID_WIDTH-1:0]   tid_q;
  logic [LEN_W-1:0]      beat_count;
  logic [ERR_W-1:0]      pkt_errs;

  logic [THR_W-1:0]      thr_next;
  logic                  beat_acc;
  logic                  pkt_end;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [LEN_W-1:0]      count_next;
  logic [ERR_W-1:0]      beat_errs;
  logic [ERR_W-1:0]      errs_next;
  logic [ERR_W-1:0]      fin_errs;
  logic                  len_err;

  // Per-beat decode: expected word, running length and the errors this beat contributes
  always_comb begin
    thr_next   = {thr_lfsr[THR_W-2:0],
                  thr_lfsr[15] ^ thr_lfsr[13] ^ thr_lfsr[12] ^ thr_lfsr[10]};
    beat_acc   = s_axis_tvalid & s_axis_tready;
    pkt_end    = beat_acc & s_axis_tlast;
    exp_word   = {prev_word[DATA_WIDTH-2:0], ^(prev_word & TAPS)};
    beat_errs  = '0;
    errs_next  = '0;
    count_next = LEN_W'(1);
    if (state == S_FIRST) begin
      beat_errs[E_ZERO] = (s_axis_tdata == '0);
      beat_errs[E_CH]   = (s_axis_tid < cntrl_min_channel_i) ||
                          (s_axis_tid > cntrl_max_channel_i);
      errs_next         = beat_errs;
    end else begin
      beat_errs[E_DATA] = (s_axis_tdata != exp_word);
      beat_errs[E_CH]   = (s_axis_tid != tid_q);
      errs_next         = pkt_errs | beat_errs;
      count_next        = (beat_count == LEN_MAX) ? LEN_MAX : beat_count + LEN_W'(1);
    end
    len_err         = (count_next < cntrl_min_length_i) || (count_next > cntrl_max_length_i);
    fin_errs        = errs_next;
    fin_errs[E_LEN] = len_err;
  end

  // Throttle LFSR and registered ready derived from its next value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_lfsr      <= THR_SEED;
      s_axis_tready <= 1'b1;
    end else begin
      thr_lfsr      <= thr_next;
      s_axis_tready <= ((thr_next & cntrl_ready_mask_i) == '0);
    end
  end

  // Packet FSM: tracks first/body beats and accumulates per-packet errors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FIRST;
      prev_word  <= '0;
      tid_q      <= '0;
      beat_count <= '0;
      pkt_errs   <= '0;
    end else if (beat_acc) begin
      // Always resync to the received word so a single bad word costs at most two mismatches
      prev_word  <= s_axis_tdata;
      beat_count <= count_next;
      pkt_errs   <= errs_next;
      if (state == S_FIRST) begin
        tid_q <= s_axis_tid;
      end
      state <= s_axis_tlast ? S_FIRST : S_BODY;
    end
  end

  // Completion pulse, one cycle after the tlast beat is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_done_o <= 1'b0;
      pkt_err_o  <= 1'b0;
    end else begin
      pkt_done_o <= pkt_end;
      pkt_err_o  <= pkt_end & (|fin_errs);
    end
  end

  // Statistics: updated alongside the completion pulse; clear takes priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_pkt_cnt_o   <= '0;
      stat_err_cnt_o   <= '0;
      stat_err_flags_o <= '0;
    end else if (cntrl_clear_i) begin
      stat_pkt_cnt_o   <= '0;
      stat_err_cnt_o   <= '0;
      stat_err_flags_o <= '0;
    end else if (pkt_end) begin
      stat_pkt_cnt_o   <= stat_pkt_cnt_o + 32'd1;
      if (|fin_errs) begin
        stat_err_cnt_o <= stat_err_cnt_o + 32'd1;
      end
      stat_err_flags_o <= stat_err_flags_o | fin_errs;
    end
  end

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Directed self-checking bench for axis_lfsr_checker.
module tb_axis_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [9:0]  s_axis_tid;
  logic [15:0] cntrl_min_length_i;
  logic [15:0] cntrl_max_length_i;
  logic [9:0]  cntrl_min_channel_i;
  logic [9:0]  cntrl_max_channel_i;
  logic [15:0] cntrl_ready_mask_i;
  logic        cntrl_clear_i;
  logic        pkt_done_o;
  logic        pkt_err_o;
  logic [31:0] stat_pkt_cnt_o;
  logic [31:0] stat_err_cnt_o;
  logic [3:0]  stat_err_flags_o;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int low_cnt  = 0;

  axis_lfsr_checker dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tid          (s_axis_tid),
    .cntrl_min_length_i  (cntrl_min_length_i),
    .cntrl_max_length_i  (cntrl_max_length_i),
    .cntrl_min_channel_i (cntrl_min_channel_i),
    .cntrl_max_channel_i (cntrl_max_channel_i),
    .cntrl_ready_mask_i  (cntrl_ready_mask_i),
    .cntrl_clear_i       (cntrl_clear_i),
    .pkt_done_o          (pkt_done_o),
    .pkt_err_o           (pkt_err_o),
    .stat_pkt_cnt_o      (stat_pkt_cnt_o),
    .stat_err_cnt_o      (stat_err_cnt_o),
    .stat_err_flags_o    (stat_err_flags_o)
  );

  always #5 clk = ~clk;

  // Count completion pulses and throttled cycles on the inactive edge
  always @(negedge clk) begin
    if (pkt_done_o) done_cnt++;
    if (!s_axis_tready) low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    return {w[30:0], ^(w & 32'h8020_0003)};
  endfunction

  // Present one beat from a negedge and return at the negedge after it is accepted
  task automatic send_beat(input logic [31:0] d, input logic [9:0] id, input logic last);
    int  waits;
    logic rdy;
    waits = 0;
    s_axis_tdata  = d;
    s_axis_tid    = id;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    forever begin
      rdy = s_axis_tready;
      @(negedge clk);
      if (rdy) break;
      waits++;
      if (waits > 200) begin
        n_checks++;
        $display("FAIL ready_timeout: got no acceptance within 200 cycles, required acceptance");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Packet of len beats from seed; optional corrupted beat and mid-packet tid switch
  task automatic send_pkt(input logic [31:0] seed, input int len, input logic [9:0] id,
                          input int bad_beat, input logic [31:0] bad_val,
                          input int sw_beat, input logic [9:0] id2);
    logic [31:0] w;
    logic [31:0] d;
    logic [9:0]  cur_id;
    w = seed;
    for (int i = 1; i <= len; i++) begin
      d      = (i == bad_beat) ? bad_val : w;
      cur_id = (sw_beat != 0 && i >= sw_beat) ? id2 : id;
      send_beat(d, cur_id, (i == len));
      w = lfsr_next(w);
    end
  endtask

  task automatic expect_done(input string tag, input logic err);
    check({tag, "_done"}, 32'(pkt_done_o), 32'd1);
    check({tag, "_err"},  32'(pkt_err_o),  32'(err));
  endtask

  task automatic clear_stats();
    cntrl_clear_i = 1'b1;
    @(negedge clk);
    cntrl_clear_i = 1'b0;
  endtask

  task automatic expect_stats(input string tag, input logic [31:0] pkts,
                              input logic [31:0] errs, input logic [3:0] flags);
    check({tag, "_pkt_cnt"}, stat_pkt_cnt_o, pkts);
    check({tag, "_err_cnt"}, stat_err_cnt_o, errs);
    check({tag, "_flags"},   32'(stat_err_flags_o), 32'(flags));
  endtask

  initial begin
    int          d0;
    int          l0;
    int          pkts;
    int          idx;
    int          cyc;
    logic [31:0] w;
    logic        rdy;
    logic        saw0;
    logic        saw1;

    reset_n             = 1'b0;
    s_axis_tdata        = '0;
    s_axis_tvalid       = 1'b0;
    s_axis_tlast        = 1'b0;
    s_axis_tid          = '0;
    cntrl_min_length_i  = 16'd1;
    cntrl_max_length_i  = 16'd16;
    cntrl_min_channel_i = 10'd0;
    cntrl_max_channel_i = 10'd15;
    cntrl_ready_mask_i  = 16'h0000;
    cntrl_clear_i       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tready", 32'(s_axis_tready), 32'd1);
    check("rst_done",   32'(pkt_done_o),    32'd0);
    check("rst_err",    32'(pkt_err_o),     32'd0);
    expect_stats("rst", 32'd0, 32'd0, 4'b0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Three clean 4-beat packets, mask 0
    d0 = done_cnt; l0 = low_cnt;
    for (int p = 0; p < 3; p++) begin
      send_pkt(32'h0000_0001, 4, 10'd5, 0, '0, 0, '0);
      expect_done("clean", 1'b0);
    end
    @(negedge clk);
    check("clean_tready_low", 32'(low_cnt - l0), 32'd0);
    check("clean_done_pulses", 32'(done_cnt - d0), 32'd3);
    expect_stats("clean", 32'd3, 32'd0, 4'b0000);

    // Corrupted beat 3 of packet 2
    clear_stats();
    send_pkt(32'h0000_0001, 4, 10'd5, 0, '0, 0, '0);
    expect_done("corr_p1", 1'b0);
    send_pkt(32'h0000_0001, 4, 10'd5, 3, 32'hDEAD_BEEF, 0, '0);
    expect_done("corr_p2", 1'b1);
    send_pkt(32'h0000_0001, 4, 10'd5, 0, '0, 0, '0);
    expect_done("corr_p3", 1'b0);
    expect_stats("corr", 32'd3, 32'd1, 4'b0100);

    // Length bounds: 20 beats over max 16, then 1 beat under min 2
    clear_stats();
    send_pkt(32'h0000_0001, 20, 10'd5, 0, '0, 0, '0);
    expect_done("len_long", 1'b1);
    cntrl_min_length_i = 16'd2;
    send_pkt(32'h0000_0007, 1, 10'd5, 0, '0, 0, '0);
    expect_done("len_short", 1'b1);
    expect_stats("len", 32'd2, 32'd2, 4'b0001);
    cntrl_min_length_i = 16'd1;

    // Channel: out of range, then tid change mid-packet
    clear_stats();
    send_pkt(32'h0000_0001, 4, 10'd20, 0, '0, 0, '0);
    expect_done("ch_range", 1'b1);
    send_pkt(32'h0000_0001, 4, 10'd5, 0, '0, 3, 10'd6);
    expect_done("ch_switch", 1'b1);
    expect_stats("ch", 32'd2, 32'd2, 4'b0010);

    // Randomized backpressure with valid held high, back-to-back 5-beat packets
    clear_stats();
    cntrl_ready_mask_i = 16'h0003;
    d0 = done_cnt; pkts = 0; idx = 1; w = 32'h0000_1234; saw0 = 1'b0; saw1 = 1'b0; cyc = 0;
    while ((cyc < 1000 || idx != 1) && cyc < 3000) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = w;
      s_axis_tid    = 10'd3;
      s_axis_tlast  = (idx == 5);
      rdy = s_axis_tready;
      if (rdy) saw1 = 1'b1; else saw0 = 1'b1;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        if (idx == 5) begin
          pkts++; idx = 1; w = 32'h0000_1234;
        end else begin
          idx++; w = lfsr_next(w);
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cntrl_ready_mask_i = 16'h0000;
    repeat (3) @(negedge clk);
    check("bp_saw_low",  32'(saw0), 32'd1);
    check("bp_saw_high", 32'(saw1), 32'd1);
    check("bp_pkts_nonzero", 32'(pkts > 0), 32'd1);
    check("bp_done_pulses", 32'(done_cnt - d0), 32'(pkts));
    expect_stats("bp", 32'(pkts), 32'd0, 4'b0000);

    // Clear in the same cycle as the 7th done pulse, then seed-0 packet
    clear_stats();
    for (int p = 0; p < 7; p++) send_pkt(32'h0000_0001, 4, 10'd5, 0, '0, 0, '0);
    expect_done("clr7", 1'b0);
    check("clr7_pkt_cnt", stat_pkt_cnt_o, 32'd7);
    cntrl_clear_i = 1'b1;
    @(negedge clk);
    cntrl_clear_i = 1'b0;
    expect_stats("clr7_after", 32'd0, 32'd0, 4'b0000);
    send_pkt(32'h0000_0001, 4, 10'd5, 0, '0, 0, '0);
    check("clr7_next_pkt_cnt", stat_pkt_cnt_o, 32'd1);
    send_pkt(32'h0000_0000, 2, 10'd5, 0, '0, 0, '0);
    expect_done("zero_seed", 1'b1);
    expect_stats("zero_seed", 32'd2, 32'd1, 4'b1000);

    // Clear coinciding with the tlast acceptance: packet not counted, pulse still seen
    send_beat(32'h0000_0001, 10'd20, 1'b0);
    cntrl_clear_i = 1'b1;
    send_beat(32'h0000_0003, 10'd20, 1'b1);
    cntrl_clear_i = 1'b0;
    expect_done("clr_update", 1'b1);
    expect_stats("clr_update", 32'd0, 32'd0, 4'b0000);

    // Async reset mid-packet discards the partial packet
    send_beat(32'h0000_0001, 10'd5, 1'b0);
    send_beat(32'h0000_0003, 10'd5, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_pkt(32'h0000_0055, 3, 10'd5, 0, '0, 0, '0);
    expect_done("post_rst", 1'b0);
    expect_stats("post_rst", 32'd1, 32'd0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
